// File: rtl/multicycle_control_unit.sv
`timescale 1ns/1ps
// multicycle_control_unit
//   Control sequencer for the multi-cycle MIPS datapath. Walks each
//   instruction through fetch/decode/execute/memory/writeback, drives the
//   shared-ALU, IR, PC and memory enables, stalls on memory wait states,
//   counts retired instructions and flags undefined opcodes.
//
// Ports
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   opcode[5:0]         IR opcode field, valid from DECODE onward
//   mem_ready           memory finishes the access this cycle
//   pcwrite, pcwrite_cond, branch_ne, pcsrc[1:0]   PC update control
//   iord, memread, memwrite, irwrite               memory / IR control
//   memtoreg, regdst, regwrite, link               register file control
//   alusrca, alusrcb[1:0], aluop[1:0]              ALU operand / op select
//   illegal_op          one-cycle pulse on an undefined opcode
//   instr_done          one-cycle pulse when an instruction retires
//   instr_count         retired-instruction count (wraps)
//   state[3:0]          current state encoding, debug only
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | after reset, all outputs quiet, moves to FETCH
// FETCH    | read instruction at PC, PC+4; IR/PC load on mem_ready
// DECODE   | latch opcode, precompute branch target, dispatch
// MEMADR   | lw/sw address = A + sext(imm)
// MEMRD    | data read at ALUOut, waits on mem_ready
// MEMWB    | write MDR to rt, retire
// MEMWR    | data write at ALUOut, retire on mem_ready
// EXEC     | R-type ALU op on A, B
// ALUWB    | write ALUOut to rd, retire
// IMMEXEC  | immediate ALU op on A, sext(imm)
// IMMWB    | write ALUOut to rt, retire
// BRANCH   | compare A, B; conditional PC load from ALUOut, retire
// JUMP     | PC <- jump target, retire
// JAL      | PC <- jump target, r31 <- PC, retire

module multicycle_control_unit #(
   parameter int CNT_W    = 32,
   parameter bit HAS_LINK = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             pcwrite,
   output logic             pcwrite_cond,
   output logic             branch_ne,
   output logic             iord,
   output logic             memread,
   output logic             memwrite,
   output logic             irwrite,
   output logic             memtoreg,
   output logic             regdst,
   output logic             regwrite,
   output logic             link,
   output logic             alusrca,
   output logic [1:0]       alusrcb,
   output logic [1:0]       aluop,
   output logic [1:0]       pcsrc,
   output logic             illegal_op,
   output logic             instr_done,
   output logic [CNT_W-1:0] instr_count,
   output logic [3:0]       state
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADR  = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_EXEC    = 4'd7,
      S_ALUWB   = 4'd8,
      S_IMMEXEC = 4'd9,
      S_IMMWB   = 4'd10,
      S_BRANCH  = 4'd11,
      S_JUMP    = 4'd12,
      S_JAL     = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   state_t           state_q, state_d;
   logic [5:0]       op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      cnt_d        = cnt_q;
      pcwrite      = 1'b0;
      pcwrite_cond = 1'b0;
      branch_ne    = 1'b0;
      iord         = 1'b0;
      memread      = 1'b0;
      memwrite     = 1'b0;
      irwrite      = 1'b0;
      memtoreg     = 1'b0;
      regdst       = 1'b0;
      regwrite     = 1'b0;
      link         = 1'b0;
      alusrca      = 1'b0;
      alusrcb      = 2'b00;
      aluop        = 2'b00;
      pcsrc        = 2'b00;
      illegal_op   = 1'b0;
      instr_done   = 1'b0;

      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            memread = 1'b1;
            alusrcb = 2'b01;
            // IR and PC+4 are only committed when the instruction word arrives
            if (mem_ready) begin
               irwrite = 1'b1;
               pcwrite = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            op_d    = opcode;
            case (opcode)
               OP_LW, OP_SW:                     state_d = S_MEMADR;
               OP_RTYPE:                         state_d = S_EXEC;
               OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_IMMEXEC;
               OP_J:                             state_d = S_JUMP;
               OP_JAL: begin
                  if (HAS_LINK) begin
                     state_d = S_JAL;
                  end else begin
                     illegal_op = 1'b1;
                     state_d    = S_FETCH;
                  end
               end
               default: begin
                  illegal_op = 1'b1;
                  state_d    = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            memread = 1'b1;
            iord    = 1'b1;
            if (mem_ready) begin
               state_d = S_MEMWB;
            end
         end
         S_MEMWB: begin
            regwrite   = 1'b1;
            memtoreg   = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            memwrite = 1'b1;
            iord     = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
         end
         S_EXEC: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            regdst     = 1'b1;
            regwrite   = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_IMMEXEC: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            aluop   = (op_q == OP_ADDI) ? 2'b00 : 2'b11;
            state_d = S_IMMWB;
         end
         S_IMMWB: begin
            regwrite   = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            alusrca      = 1'b1;
            aluop        = 2'b01;
            pcwrite_cond = 1'b1;
            pcsrc        = 2'b01;
            branch_ne    = (op_q == OP_BNE);
            instr_done   = 1'b1;
            state_d      = S_FETCH;
         end
         S_JUMP: begin
            pcwrite    = 1'b1;
            pcsrc      = 2'b10;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_JAL: begin
            pcwrite    = 1'b1;
            pcsrc      = 2'b10;
            regwrite   = 1'b1;
            link       = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (instr_done) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

   assign instr_count = cnt_q;
   assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
`timescale 1ns/1ps
module tb_multicycle_control_unit;

   typedef struct packed {
      logic       pcwrite;
      logic       pcwrite_cond;
      logic       branch_ne;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       irwrite;
      logic       memtoreg;
      logic       regdst;
      logic       regwrite;
      logic       link;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsrc;
      logic       illegal_op;
      logic       instr_done;
   } ctl_t;

   typedef struct {
      ctl_t        c;
      logic [31:0] cnt;
      bit          dut;
      int          cyc;
      logic [5:0]  op;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // dut a: 32-bit counter, jal supported; dut b: 4-bit counter, no jal
   logic       rstn_a = 1'b0, rstn_b = 1'b0;
   logic       mr_a = 1'b0, mr_b = 1'b0;
   logic [5:0] op_a = '0, op_b = '0;

   logic pcwrite_a, pcwrite_cond_a, branch_ne_a, iord_a, memread_a, memwrite_a;
   logic irwrite_a, memtoreg_a, regdst_a, regwrite_a, link_a, alusrca_a;
   logic illegal_op_a, instr_done_a;
   logic [1:0] alusrcb_a, aluop_a, pcsrc_a;
   logic [31:0] cnt_a;
   logic [3:0] st_a;

   logic pcwrite_b, pcwrite_cond_b, branch_ne_b, iord_b, memread_b, memwrite_b;
   logic irwrite_b, memtoreg_b, regdst_b, regwrite_b, link_b, alusrca_b;
   logic illegal_op_b, instr_done_b;
   logic [1:0] alusrcb_b, aluop_b, pcsrc_b;
   logic [3:0] cnt_b;
   logic [3:0] st_b;

   multicycle_control_unit #(.CNT_W(32), .HAS_LINK(1'b1)) dut_a (
      .clk(clk), .rst_n(rstn_a), .opcode(op_a), .mem_ready(mr_a),
      .pcwrite(pcwrite_a), .pcwrite_cond(pcwrite_cond_a), .branch_ne(branch_ne_a),
      .iord(iord_a), .memread(memread_a), .memwrite(memwrite_a), .irwrite(irwrite_a),
      .memtoreg(memtoreg_a), .regdst(regdst_a), .regwrite(regwrite_a), .link(link_a),
      .alusrca(alusrca_a), .alusrcb(alusrcb_a), .aluop(aluop_a), .pcsrc(pcsrc_a),
      .illegal_op(illegal_op_a), .instr_done(instr_done_a), .instr_count(cnt_a),
      .state(st_a)
   );

   multicycle_control_unit #(.CNT_W(4), .HAS_LINK(1'b0)) dut_b (
      .clk(clk), .rst_n(rstn_b), .opcode(op_b), .mem_ready(mr_b),
      .pcwrite(pcwrite_b), .pcwrite_cond(pcwrite_cond_b), .branch_ne(branch_ne_b),
      .iord(iord_b), .memread(memread_b), .memwrite(memwrite_b), .irwrite(irwrite_b),
      .memtoreg(memtoreg_b), .regdst(regdst_b), .regwrite(regwrite_b), .link(link_b),
      .alusrca(alusrca_b), .alusrcb(alusrcb_b), .aluop(aluop_b), .pcsrc(pcsrc_b),
      .illegal_op(illegal_op_b), .instr_done(instr_done_b), .instr_count(cnt_b),
      .state(st_b)
   );

   ctl_t act_a, act_b;
   assign act_a = {pcwrite_a, pcwrite_cond_a, branch_ne_a, iord_a, memread_a, memwrite_a,
                   irwrite_a, memtoreg_a, regdst_a, regwrite_a, link_a, alusrca_a,
                   alusrcb_a, aluop_a, pcsrc_a, illegal_op_a, instr_done_a};
   assign act_b = {pcwrite_b, pcwrite_cond_b, branch_ne_b, iord_b, memread_b, memwrite_b,
                   irwrite_b, memtoreg_b, regdst_b, regwrite_b, link_b, alusrca_b,
                   alusrcb_b, aluop_b, pcsrc_b, illegal_op_b, instr_done_b};

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   bit         cur_dut = 1'b0;
   int         cyc_no = 0;
   longint     model_cnt = 0;
   logic [5:0] cur_label = '0;

   // ---------------- monitor ----------------
   exp_t        m_e;
   ctl_t        m_act;
   logic [31:0] m_cnt;

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         m_e   = exp_q.pop_front();
         m_act = m_e.dut ? act_b : act_a;
         m_cnt = m_e.dut ? {28'd0, cnt_b} : cnt_a;
         checks++;
         if (m_act !== m_e.c) begin
            failures++;
            $display("FAIL ctl_outputs cyc=%0d dut=%0d op=%b actual=%b required=%b",
                     m_e.cyc, m_e.dut, m_e.op, m_act, m_e.c);
         end
         checks++;
         if (m_cnt !== m_e.cnt) begin
            failures++;
            $display("FAIL instr_count cyc=%0d dut=%0d op=%b actual=%0d required=%0d",
                     m_e.cyc, m_e.dut, m_e.op, m_cnt, m_e.cnt);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model helpers ----------------
   // instruction class: 0 illegal, 1 R, 2 lw, 3 sw, 4 branch, 5 imm, 6 j, 7 jal
   function automatic int kind(input logic [5:0] op, input bit haslink);
      case (op)
         6'b000000: return 1;
         6'b100011: return 2;
         6'b101011: return 3;
         6'b000100, 6'b000101: return 4;
         6'b001000, 6'b001100, 6'b001101, 6'b001111: return 5;
         6'b000010: return 6;
         6'b000011: return haslink ? 7 : 0;
         default: return 0;
      endcase
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [5:0] pick();
      logic [5:0] legal [11];
      legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000,
                6'b001100, 6'b001101, 6'b001111, 6'b000010, 6'b000011};
      if ($urandom_range(0, 9) < 8) return legal[$urandom_range(0, 10)];
      return 6'($urandom);
   endfunction

   task automatic drive(input logic [5:0] op, input logic mr, input logic rn);
      @(posedge clk);
      #1;
      cyc_no++;
      if (cur_dut == 1'b0) begin
         op_a = op; mr_a = mr; rstn_a = rn;
      end else begin
         op_b = op; mr_b = mr; rstn_b = rn;
      end
   endtask

   task automatic push(input ctl_t c);
      exp_t e;
      e.c   = c;
      e.dut = cur_dut;
      e.cyc = cyc_no;
      e.op  = cur_label;
      e.cnt = cur_dut ? 32'(model_cnt % 16) : 32'(model_cnt);
      exp_q.push_back(e);
      if (c.instr_done) model_cnt++;
   endtask

   task automatic do_reset();
      ctl_t c;
      drive(6'd0, 1'b0, 1'b0);
      model_cnt = 0;
      drive(6'd0, rb(), 1'b1);
      c = '0;
      push(c);
   endtask

   // opcode is garbage during FETCH and after DECODE: only the DECODE-cycle
   // value may matter
   task automatic run_instr(input logic [5:0] op, input int nf, input int nm);
      ctl_t c, fb;
      int   k;
      cur_label = op;
      k = kind(op, cur_dut == 1'b0);
      fb = '0; fb.memread = 1'b1; fb.alusrcb = 2'b01;
      for (int i = 0; i < nf; i++) begin
         drive(6'($urandom), 1'b0, 1'b1);
         push(fb);
      end
      drive(6'($urandom), 1'b1, 1'b1);
      c = fb; c.irwrite = 1'b1; c.pcwrite = 1'b1;
      push(c);
      drive(op, rb(), 1'b1);
      c = '0; c.alusrcb = 2'b11; c.illegal_op = (k == 0);
      push(c);
      case (k)
         1: begin
            drive(6'($urandom), rb(), 1'b1);
            c = '0; c.alusrca = 1'b1; c.aluop = 2'b10; push(c);
            drive(6'($urandom), rb(), 1'b1);
            c = '0; c.regdst = 1'b1; c.regwrite = 1'b1; c.instr_done = 1'b1; push(c);
         end
         2, 3: begin
            drive(6'($urandom), rb(), 1'b1);
            c = '0; c.alusrca = 1'b1; c.alusrcb = 2'b10; push(c);
            fb = '0; fb.iord = 1'b1;
            if (k == 2) fb.memread = 1'b1; else fb.memwrite = 1'b1;
            for (int i = 0; i < nm; i++) begin
               drive(6'($urandom), 1'b0, 1'b1);
               push(fb);
            end
            drive(6'($urandom), 1'b1, 1'b1);
            c = fb; c.instr_done = (k == 3); push(c);
            if (k == 2) begin
               drive(6'($urandom), rb(), 1'b1);
               c = '0; c.regwrite = 1'b1; c.memtoreg = 1'b1; c.instr_done = 1'b1; push(c);
            end
         end
         4: begin
            drive(6'($urandom), rb(), 1'b1);
            c = '0; c.alusrca = 1'b1; c.aluop = 2'b01; c.pcwrite_cond = 1'b1;
            c.pcsrc = 2'b01; c.branch_ne = (op == 6'b000101); c.instr_done = 1'b1;
            push(c);
         end
         5: begin
            drive(6'($urandom), rb(), 1'b1);
            c = '0; c.alusrca = 1'b1; c.alusrcb = 2'b10;
            c.aluop = (op == 6'b001000) ? 2'b00 : 2'b11;
            push(c);
            drive(6'($urandom), rb(), 1'b1);
            c = '0; c.regwrite = 1'b1; c.instr_done = 1'b1; push(c);
         end
         6, 7: begin
            drive(6'($urandom), rb(), 1'b1);
            c = '0; c.pcwrite = 1'b1; c.pcsrc = 2'b10; c.instr_done = 1'b1;
            if (k == 7) begin c.regwrite = 1'b1; c.link = 1'b1; end
            push(c);
         end
         default: ;
      endcase
   endtask

   // sw stalled in MEMWR, reset lands mid-instruction
   task automatic reset_in_memwr();
      ctl_t c;
      logic m;
      logic [5:0] op;
      op = 6'b101011;
      cur_label = op;
      drive(op, 1'b1, 1'b1);
      c = '0; c.memread = 1'b1; c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1; push(c);
      drive(op, 1'b0, 1'b1);
      c = '0; c.alusrcb = 2'b11; push(c);
      drive(op, 1'b0, 1'b1);
      c = '0; c.alusrca = 1'b1; c.alusrcb = 2'b10; push(c);
      drive(op, 1'b0, 1'b1);
      c = '0; c.memwrite = 1'b1; c.iord = 1'b1; push(c);
      m = rb();
      drive(op, m, 1'b0);
      c = '0; c.memwrite = 1'b1; c.iord = 1'b1; c.instr_done = m; push(c);
      model_cnt = 0;
      drive(op, rb(), 1'b1);
      c = '0; push(c);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int guard;
      cur_dut = 1'b0;
      do_reset();
      run_instr(6'b000000, 0, 0);
      run_instr(6'b100011, 2, 2);
      run_instr(6'b000101, 0, 0);
      run_instr(6'b000100, 1, 0);
      run_instr(6'b000011, 0, 0);
      run_instr(6'b111111, 0, 0);
      run_instr(6'b101011, 0, 1);
      run_instr(6'b000010, 0, 0);
      run_instr(6'b001000, 0, 0);
      run_instr(6'b001100, 0, 0);
      run_instr(6'b001101, 0, 0);
      run_instr(6'b001111, 0, 0);
      reset_in_memwr();
      run_instr(6'b000000, 0, 0);
      repeat (150) run_instr(pick(), $urandom_range(0, 2), $urandom_range(0, 3));

      cur_dut = 1'b1;
      do_reset();
      run_instr(6'b000011, 0, 0);
      guard = 0;
      while (model_cnt < 20 && guard < 300) begin
         run_instr(pick(), $urandom_range(0, 1), $urandom_range(0, 2));
         guard++;
      end

      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore/Mealy FSM sequencer for the multi-cycle MIPS datapath. It is the next generation of the single-cycle opcode decoder.
- Steps each instruction through fetch, decode, execute, memory and writeback states, and drives the shared-ALU, IR, PC and memory enables.
- Adds a memory wait-state handshake, a retired-instruction counter and illegal-opcode flagging.
- Sits between the instruction register opcode field and the multi-cycle datapath muxes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- HAS_LINK, 1, 1 = jal supported; 0 = opcode 000011 treated as illegal.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- opcode  in  6  instr[31:26] from the IR; valid from DECODE onward.
- mem_ready  in  1  memory completes the access this cycle.
- pcwrite  out  1  unconditional PC load.
- pcwrite_cond  out  1  PC load if the branch condition holds.
- branch_ne  out  1  1 = bne sense (take on !zero); 0 = beq.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memread  out  1  memory read request.
- memwrite  out  1  memory write request.
- irwrite  out  1  IR load.
- memtoreg  out  1  register write data: 1 = MDR, 0 = ALUOut.
- regdst  out  1  destination register: 1 = rd, 0 = rt.
- regwrite  out  1  register file write.
- link  out  1  force destination reg 31 and write data = PC (jal).
- alusrca  out  1  ALU A input: 0 = PC, 1 = reg A.
- alusrcb  out  2  ALU B input: 00 = reg B, 01 = const 4, 10 = sext imm, 11 = sext imm<<2.
- aluop  out  2  00 = add, 01 = sub, 10 = funct, 11 = immediate-logic.
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- instr_count  out  CNT_W  retired-instruction count.
- state  out  4  current state encoding, for debug.

Behaviour:
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, IMMEXEC, IMMWB, BRANCH, JUMP, JAL.
- Reset: any clk edge with rst_n=0 sets state=IDLE, instr_count=0 and the opcode latch=0. This applies mid-instruction too; the in-flight instruction is abandoned and not counted.
- Output defaults: every output is 0 in any state unless listed below. IDLE drives all outputs 0. IDLE always goes to FETCH on the next edge.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite and pcwrite are asserted only in a cycle with mem_ready=1 (Mealy).
  - mem_ready=1 -> DECODE; otherwise stay in FETCH.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (precomputes the branch target). Latch opcode. Next state:
  - 100011 or 101011 -> MEMADR.
  - 000000 -> EXEC.
  - 000100 or 000101 -> BRANCH.
  - 001000, 001100, 001101, 001111 -> IMMEXEC.
  - 000010 -> JUMP.
  - 000011 -> JAL if HAS_LINK=1.
  - Anything else -> FETCH with illegal_op=1 for this cycle. Not retired, counter unchanged.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD if the latched opcode is lw, else MEMWR.
- MEMRD: memread=1, iord=1. Waits for mem_ready, then -> MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. -> FETCH, retire.
- MEMWR: memwrite=1, iord=1. Waits for mem_ready; retires and goes to FETCH in the mem_ready cycle.
- EXEC: alusrca=1, alusrcb=00, aluop=10. -> ALUWB.
- ALUWB: regdst=1, regwrite=1. -> FETCH, retire.
- IMMEXEC: alusrca=1, alusrcb=10. aluop=00 for addi, 11 for andi/ori/lui. -> IMMWB.
- IMMWB: regdst=0, regwrite=1. -> FETCH, retire.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwrite_cond=1, pcsrc=01, branch_ne=(latched opcode==000101). -> FETCH, retire.
- JUMP: pcwrite=1, pcsrc=10. -> FETCH, retire.
- JAL: pcwrite=1, pcsrc=10, regwrite=1, link=1. -> FETCH, retire.
- Retire:
  - instr_done=1 combinationally in the final state's exit cycle.
  - instr_count increments on that edge and is visible the next cycle.
  - Wraps from 2^CNT_W-1 to 0.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR. memread/memwrite stay high for the whole wait.
- Latency with mem_ready tied to 1: R/immediate 4 cycles, lw 5, sw 4, beq/bne 3, j/jal 3.

Test Plan:
- Reset then R-type (000000), mem_ready=1:
  - Path IDLE -> FETCH -> DECODE -> EXEC -> ALUWB.
  - ALUWB has regdst=1, regwrite=1. instr_count=1 after 4 cycles from FETCH.
- lw (100011) with mem_ready low for 2 cycles in both FETCH and MEMRD:
  - FETCH lasts 3 cycles; irwrite pulses only in the 3rd.
  - MEMRD lasts 3 cycles; MEMWB has memtoreg=1, regwrite=1.
  - 9 cycles total.
- bne (000101) -> BRANCH has pcwrite_cond=1, branch_ne=1, aluop=01, pcsrc=01. beq gives branch_ne=0.
- jal (000011):
  - HAS_LINK=1: JAL has pcwrite=1, pcsrc=10, regwrite=1, link=1.
  - HAS_LINK=0: illegal_op pulses in DECODE and instr_count is unchanged.
- Opcode 111111 -> illegal_op=1 for one cycle, return to FETCH, instr_done=0.
- Reset asserted in MEMWR, plus counter wrap:
  - rst_n=0 in MEMWR: next edge state=IDLE, all outputs 0, instr_count=0.
  - CNT_W=4: after 16 retires instr_count reads 0.
